// File: rtl/mult_addshift_param_if.sv
// Operand/handshake bundle for the sequential add/shift multiplier.
// The master drives commands and operands; the slave (the multiplier) returns
// the product registers and status.
interface mult_addshift_param_if #(
  parameter int W = 8
);
  logic         Start;
  logic         Signed_i;
  logic         Load_B;
  logic         Clr_A;
  logic [W-1:0] Din;
  logic         X;
  logic [W-1:0] Aval;
  logic [W-1:0] Bval;
  logic         Busy;
  logic         Done;

  modport master (
    output Start, Signed_i, Load_B, Clr_A, Din,
    input  X, Aval, Bval, Busy, Done
  );

  modport slave (
    input  Start, Signed_i, Load_B, Clr_A, Din,
    output X, Aval, Bval, Busy, Done
  );
endinterface

// File: rtl/mult_addshift_param.sv
// Sequential add/shift multiplier, W-bit operands, 2W-bit product in {A,B}.
// One iteration per clock; signed mode uses a subtract on the final
// iteration so the multiplier's sign bit carries negative weight.
module mult_addshift_param #(
  parameter int W  = 8,
  parameter int CW = $clog2(W)
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  mult_addshift_param_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic            x_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    s_q;
  logic [CW-1:0]   count;
  logic            sgn;
  logic            busy_q;
  logic            done_q;
  logic [2*W:0]    step;

  // One add/shift iteration: returns {X, A, B} after the shift.
  // The sum is formed at W+1 bits so the unsigned carry and the signed
  // extension bit are both kept before shifting into A.
  function automatic logic [2*W:0] iterate(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [W-1:0] s,
    input logic         sg,
    input logic         last
  );
    logic [W:0] ea;
    logic [W:0] es;
    logic [W:0] r;
    ea = sg ? {a[W-1], a} : {1'b0, a};
    es = sg ? {s[W-1], s} : {1'b0, s};
    if (!b[0])
      r = ea;
    else if (sg && last)
      r = ea + ~es + (W+1)'(1);
    else
      r = ea + es;
    return {(sg ? r[W] : 1'b0), r[W], r[W-1:1], r[0], b[W-1:1]};
  endfunction

  // Next-iteration value of the product registers for the current CALC cycle.
  always_comb begin
    step = iterate(a_q, b_q, s_q, sgn, (count == CW'(W-1)));
  end

  // Control FSM and datapath registers; reset clears everything at once.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      x_q    <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      count  <= '0;
      sgn    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.Start) begin
            state  <= CALC;
            x_q    <= 1'b0;
            a_q    <= '0;
            s_q    <= bus.Din;
            sgn    <= bus.Signed_i;
            count  <= '0;
            busy_q <= 1'b1;
          end else begin
            if (bus.Load_B)
              b_q <= bus.Din;
            if (bus.Clr_A) begin
              x_q <= 1'b0;
              a_q <= '0;
            end
          end
        end
        CALC: begin
          x_q   <= step[2*W];
          a_q   <= step[2*W-1:W];
          b_q   <= step[W-1:0];
          count <= count + CW'(1);
          if (count == CW'(W-1)) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.X    = x_q;
  assign bus.Aval = a_q;
  assign bus.Bval = b_q;
  assign bus.Busy = busy_q;
  assign bus.Done = done_q;

endmodule
